niosii_irq_ctrl: RTL and testbench
==================================

# niosII_irq_ctrl

Avalon-MM interrupt aggregator between the system's interrupt sources (the sys_clk timer `irq` and peripheral IRQ lines) and the Nios II CPU interrupt input. It:
- latches up to 16 IRQ lines, each in level or rising-edge mode;
- masks them per line;
- drives a single combined `irq_out`;
- reports the lowest-numbered active line through a read-only ID register.

All sources are synchronous to `clk`.

## Interface

- `NUM_IRQ`, default 8: number of IRQ inputs, legal range 1..16.

- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 2: register select, word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && ~write_n`.
- `writedata` input 16: write data.
- `readdata` output 16: registered read data, latency 1.
- `irq_in` input NUM_IRQ: interrupt sources, bit 0 = sys_clk timer.
- `irq_out` output 1: combined interrupt to CPU, active high.

## Operation

- **Register map** (16-bit; bits at or above NUM_IRQ read 0 and ignore writes):
  - 0 PENDING: read pending bits. Write 1 clears edge-mode bits; level-mode bits ignore writes.
  - 1 ENABLE: read/write mask; 1 = line may assert `irq_out`.
  - 2 EDGE: read/write mode; 1 = rising-edge latched, 0 = level.
  - 3 ACTIVE: read-only.
    - bit15 = valid.
    - bits 3:0 = index of the lowest-numbered bit set in PENDING & ENABLE.
    - Reads 0 when none is set. Writes ignored.
- `irq_q` holds `irq_in` from the previous clock. `rise = irq_in & ~irq_q`.
- **Level line** (EDGE[i]=0): `pending[i] <= irq_in[i]` every clock. Cleared only by the source deasserting (e.g. the timer's status write).
- **Edge line** (EDGE[i]=1):
  - `pending[i]` sets on `rise[i]`.
  - It clears on a PENDING write with `writedata[i]=1`.
  - If both happen in the same cycle, set wins.
- **EDGE write:** for every bit whose mode changes, `pending[i]` is forced to 0 that cycle. Level bits resume sampling on the next clock.
- `irq_out = |(pending & enable)`, decoded combinationally from registers. No glitch sources beyond register outputs.
- **ACTIVE:** registered priority encode of `pending & enable`, updated every clock. Lowest index has highest priority.
- **readdata:** mux of the register selected by `address`, registered every clock regardless of `chipselect`, as in the sys_clk timer slave.
- **Reset** (asynchronous, immediate) clears the following to 0:
  - `pending`, `enable`, `edge`, `irq_q`, ACTIVE, `readdata`.
  - Consequently `irq_out` = 0.
- Reset asserted mid-operation discards all pending state. After release, level lines re-sample on the first clock.

## Timing

- **Input to output:** `irq_in[i]` high at rising edge k → `pending[i]` = 1 after edge k. `irq_out` is high after edge k if ENABLE[i]=1.
- **ACTIVE:** reflects `pending & enable` one clock after pending/enable change, i.e. after edge k+1.
- **Reads:** address presented at edge k → `readdata` valid after edge k. Reads have no side effects.
- **Writes:** take effect after the edge they are sampled on.
  - An ENABLE write at edge k changes `irq_out` after edge k.
  - A PENDING clear at edge k deasserts `irq_out` after edge k, unless a new rise coincides.
- **Edge-mode pulse:** a 1-cycle pulse on an edge-mode line is always captured. A line held high produces only one pending set until it falls and rises again.

## Test plan

- **Reset defaults:** assert `reset` mid-run with `irq_in=8'hFF` → `irq_out=0` and `readdata=0` immediately. Read of ENABLE and EDGE after release returns 0.
- **Level timer path:**
  - Setup: ENABLE=0x0001, EDGE=0; drive `irq_in[0]` high at edge 10.
  - Required: `irq_out`=1 after edge 10; ACTIVE reads 0x8000.
  - Drop `irq_in[0]` → `irq_out`=0 next cycle. Writing PENDING=1 while the input is high has no effect.
- **Edge latch and clear:**
  - Setup: EDGE=0x0004, ENABLE=0x0004; 1-cycle pulse on `irq_in[2]`.
  - Required: PENDING reads 0x0004 and ACTIVE reads 0x8002.
  - Write PENDING=0x0004 → `irq_out`=0. A second pulse in the same cycle as the clear keeps PENDING=0x0004.
- **Priority and mask:**
  - Setup: pend lines 5 and 3 in edge mode, ENABLE=0x0020.
  - Required: ACTIVE=0x8005.
  - Set ENABLE=0x0028 → ACTIVE=0x8003 one clock later. ENABLE=0 → `irq_out`=0 with PENDING still 0x0028.
- **Mode switch:** line 1 pending in edge mode; write EDGE=0 while `irq_in[1]=0` → PENDING bit1=0 after that edge and stays 0.
- **Unused bits** (NUM_IRQ=4): write 0xFFFF to ENABLE/EDGE → both read 0x000F; PENDING bits 15:4 always read 0.

Source files
------------

// File: rtl/niosii_irq_ctrl.sv
// niosii_irq_ctrl: Avalon-MM interrupt aggregator with per-line mask, level/edge mode and priority ID register
module niosii_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);
  logic [NUM_IRQ-1:0] pending, enable, edge_mode, irq_q;
  logic [NUM_IRQ-1:0] rise, clr, mode_chg, pend_nxt, pe;
  logic [15:0] active, active_nxt, rd_mux;
  logic wr, unused_wd;
  assign unused_wd = ^writedata;
  assign wr = chipselect & ~write_n;
  assign rise = irq_in & ~irq_q;
  assign clr = (wr && address == 2'd0) ? writedata[NUM_IRQ-1:0] : '0;
  assign mode_chg = (wr && address == 2'd2) ? (edge_mode ^ writedata[NUM_IRQ-1:0]) : '0;
  assign pend_nxt = ~mode_chg & ((edge_mode & (rise | (pending & ~clr))) | (~edge_mode & irq_in));
  assign pe = pending & enable;
  assign irq_out = |pe;
  assign rd_mux = address == 2'd0 ? 16'(pending) :
                  address == 2'd1 ? 16'(enable) :
                  address == 2'd2 ? 16'(edge_mode) : active;
  // priority encode: scan downward so the lowest set index is written last and wins
  always_comb begin
    active_nxt = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pe[i]) active_nxt = {1'b1, 11'd0, 4'(i)};
  end
  // register file, pending latches, input history, ID and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      irq_q     <= '0;
      active    <= '0;
      readdata  <= '0;
    end else begin
      pending   <= pend_nxt;
      enable    <= (wr && address == 2'd1) ? writedata[NUM_IRQ-1:0] : enable;
      edge_mode <= (wr && address == 2'd2) ? writedata[NUM_IRQ-1:0] : edge_mode;
      irq_q     <= irq_in;
      active    <= active_nxt;
      readdata  <= rd_mux;
    end
  end
endmodule

// File: tb/tb_niosii_irq_ctrl.sv
// tb_niosii_irq_ctrl: scoreboard bench for the interrupt aggregator (8-line and 4-line instances)
module tb_niosii_irq_ctrl;
  typedef struct {
    bit          d4;
    bit          is_irq;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk = 0, reset = 1;
  logic [1:0] address = 0;
  logic chipselect = 0, write_n = 1;
  logic [15:0] writedata = 0;
  logic [7:0] irq_in = 0, irq_v = 0;
  logic [15:0] rd8, rd4, act;
  logic irq8, irq4;
  logic chk_req = 0, sample_q = 0, async_chk = 0;
  exp_t sbq[$], stage[$], e;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  niosii_irq_ctrl #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd8), .irq_in(irq_in), .irq_out(irq8));

  niosii_irq_ctrl #(.NUM_IRQ(4)) dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd4), .irq_in(irq_in[3:0]), .irq_out(irq4));

  always @(posedge clk) sample_q <= chk_req;

  always @(negedge clk) begin
    if (sample_q || async_chk) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expect: output presented with empty scoreboard");
      end
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = e.is_irq ? {15'd0, e.d4 ? irq4 : irq8} : (e.d4 ? rd4 : rd8);
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task ex(input bit d4, input bit is_irq, input logic [15:0] v, input string n);
    stage.push_back('{d4, is_irq, v, n});
  endtask

  task commit();
    while (stage.size() > 0) sbq.push_back(stage.pop_front());
  endtask

  task step(input logic [1:0] a, input bit w, input logic [15:0] d, input bit chk);
    @(negedge clk);
    #1;
    address = a; chipselect = w; write_n = ~w; writedata = d; irq_in = irq_v; chk_req = chk;
    commit();
    @(posedge clk);
  endtask

  task rd(input logic [1:0] a, input bit chk);
    step(a, 1'b0, 16'h0, chk);
  endtask

  task wr(input logic [1:0] a, input logic [15:0] d, input bit chk);
    step(a, 1'b1, d, chk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 0;
    irq_v = 8'hFF;
    ex(0, 1, 16'h1, "pre_rst_irq"); ex(0, 0, 16'h0, "pre_rst_rd_en"); wr(1, 16'h00FF, 1);
    ex(0, 0, 16'h00FF, "pre_rst_pend"); rd(0, 1);
    rd(0, 0);
    #1 reset = 1;
    ex(0, 1, 16'h0, "async_irq"); ex(0, 0, 16'h0, "async_rd"); ex(1, 0, 16'h0, "async_rd4");
    commit();
    async_chk = 1;
    @(negedge clk); #1 async_chk = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 0; irq_v = 0; irq_in = 0;
    ex(0, 0, 16'h0, "en_after_rst"); ex(0, 1, 16'h0, "irq_after_rst"); rd(1, 1);
    ex(0, 0, 16'h0, "edge_after_rst"); rd(2, 1);
    wr(1, 16'h0001, 0);
    irq_v = 8'h01; ex(0, 1, 16'h1, "lvl_irq_up"); rd(0, 1);
    rd(0, 0);
    ex(0, 0, 16'h8000, "lvl_active"); rd(3, 1);
    ex(0, 1, 16'h1, "lvl_clr_ignored"); wr(0, 16'h0001, 1);
    irq_v = 8'h00; ex(0, 0, 16'h0001, "lvl_pend_rd"); ex(0, 1, 16'h0, "lvl_irq_down"); rd(0, 1);
    wr(1, 16'h0004, 0);
    wr(2, 16'h0004, 0);
    irq_v = 8'h04; rd(0, 0);
    irq_v = 8'h00; ex(0, 0, 16'h0004, "edge_pend"); ex(0, 1, 16'h1, "edge_irq"); rd(0, 1);
    ex(0, 0, 16'h8002, "edge_active"); rd(3, 1);
    ex(0, 1, 16'h0, "edge_clr"); wr(0, 16'h0004, 1);
    irq_v = 8'h04; ex(0, 1, 16'h1, "edge_repulse"); rd(0, 1);
    irq_v = 8'h00; rd(0, 0);
    irq_v = 8'h04; ex(0, 1, 16'h1, "clr_vs_rise"); wr(0, 16'h0004, 1);
    irq_v = 8'h00; ex(0, 0, 16'h0004, "clr_vs_rise_pend"); rd(0, 1);
    ex(0, 1, 16'h0, "edge_clr2"); wr(0, 16'h0004, 1);
    wr(2, 16'h0028, 0);
    irq_v = 8'h28; wr(1, 16'h0020, 0);
    irq_v = 8'h00; ex(0, 1, 16'h1, "prio_irq"); rd(0, 1);
    ex(0, 0, 16'h8005, "prio_active5"); rd(3, 1);
    wr(1, 16'h0028, 0);
    rd(3, 0);
    ex(0, 0, 16'h8003, "prio_active3"); rd(3, 1);
    ex(0, 1, 16'h0, "mask_all"); wr(1, 16'h0000, 1);
    ex(0, 0, 16'h0028, "mask_pend_kept"); rd(0, 1);
    wr(2, 16'h002A, 0);
    irq_v = 8'h02; rd(0, 0);
    irq_v = 8'h00; ex(0, 0, 16'h002A, "mode_pend"); rd(0, 1);
    wr(2, 16'h0028, 0);
    ex(0, 0, 16'h0028, "mode_sw_clr"); rd(0, 1);
    ex(0, 0, 16'h0028, "mode_sw_stays"); rd(0, 1);
    wr(1, 16'hFFFF, 0);
    wr(2, 16'hFFFF, 0);
    ex(1, 0, 16'h000F, "unused_en4"); ex(0, 0, 16'h00FF, "unused_en8"); rd(1, 1);
    ex(1, 0, 16'h000F, "unused_edge4"); rd(2, 1);
    irq_v = 8'hFF; rd(0, 0);
    irq_v = 8'h00; ex(1, 0, 16'h000F, "unused_pend4"); ex(0, 0, 16'h00FF, "pend8_all"); rd(0, 1);
    rd(0, 0);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared, want %h", e.name, e.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
